// File: rtl/intcnct_flit_deser.sv
// ---------------------------------------------------------------------------
// intcnct_flit_deser
//
// Receive side of the chip-to-FPGA interconnect. The chip sends each 64-bit
// NoC flit as two 32-bit words, low half first, tagged with the NoC channel
// (1..3) it belongs to. This block pairs the halves per channel, queues the
// rebuilt flits in one FIFO per channel and hands them to the consumers with
// a val/rdy handshake. Every flit taken by a consumer returns one credit to
// the sender. The sender starts with FIFO_DEPTH credits per channel.
//
// Ports
//   clk                  single clock for all logic
//   rst                  asynchronous active-high reset
//   intcnct_data_in      32-bit half-flit word from the chip
//   intcnct_channel_in   0 = idle, 1..3 = word belongs to channel 1..3
//   intcnct_credit_back  bit N-1 pulses for one cycle after each pop of ch N
//   bout_data_N          head flit of channel N FIFO, 0 while empty
//   bout_val_N           channel N FIFO is non-empty
//   bout_rdy_N           consumer takes the channel N head this cycle
//   overflow_err         sticky, bit N-1 set when a flit hit a full ch N FIFO
// ---------------------------------------------------------------------------
module intcnct_flit_deser #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] intcnct_data_in,
   input  logic [1:0]  intcnct_channel_in,
   output logic [2:0]  intcnct_credit_back,
   output logic [63:0] bout_data_1,
   output logic [63:0] bout_data_2,
   output logic [63:0] bout_data_3,
   output logic        bout_val_1,
   output logic        bout_val_2,
   output logic        bout_val_3,
   input  logic        bout_rdy_1,
   input  logic        bout_rdy_2,
   input  logic        bout_rdy_3,
   output logic [2:0]  overflow_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {
      PH_LOW,
      PH_HIGH
   } phase_t;

   phase_t        phase_q  [3];
   phase_t        phase_d  [3];
   logic [31:0]   half_q   [3];
   logic [31:0]   half_d   [3];
   logic [63:0]   mem_q    [3][FIFO_DEPTH];
   logic [63:0]   mem_d    [3][FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q [3];
   logic [AW-1:0] wr_ptr_d [3];
   logic [AW-1:0] rd_ptr_q [3];
   logic [AW-1:0] rd_ptr_d [3];
   logic [CW-1:0] count_q  [3];
   logic [CW-1:0] count_d  [3];
   logic [2:0]    credit_q;
   logic [2:0]    credit_d;
   logic [2:0]    overflow_q;
   logic [2:0]    overflow_d;

   logic [2:0]    rdy;
   logic [2:0]    word_hit;
   logic [2:0]    flit_done;
   logic [2:0]    pop;
   logic [2:0]    push;
   logic [2:0]    drop;
   logic [63:0]   head [3];

   assign rdy = {bout_rdy_3, bout_rdy_2, bout_rdy_1};

   // Per-channel next state. Each channel pairs its own halves, so words of
   // different channels can interleave without disturbing each other. A flit
   // arriving at a full FIFO is still accepted when the head leaves in the
   // same cycle, because the slot being freed is the one being written
   // (write and read pointers coincide when full). Dropped flits still
   // return the phase to LOW so the next word starts a fresh flit.
   always_comb begin
      word_hit   = '0;
      flit_done  = '0;
      pop        = '0;
      push       = '0;
      drop       = '0;
      credit_d   = '0;
      overflow_d = overflow_q;
      for (int c = 0; c < 3; c++) begin
         phase_d[c]  = phase_q[c];
         half_d[c]   = half_q[c];
         wr_ptr_d[c] = wr_ptr_q[c];
         rd_ptr_d[c] = rd_ptr_q[c];
         count_d[c]  = count_q[c];
         head[c]     = '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_d[c][i] = mem_q[c][i];
         end

         word_hit[c]  = (intcnct_channel_in == 2'(c + 1));
         flit_done[c] = word_hit[c] && (phase_q[c] == PH_HIGH);
         pop[c]       = (count_q[c] != '0) && rdy[c];
         push[c]      = flit_done[c] &&
                        ((count_q[c] != CW'(FIFO_DEPTH)) || pop[c]);
         drop[c]      = flit_done[c] && !push[c];

         if (count_q[c] != '0) begin
            head[c] = mem_q[c][rd_ptr_q[c]];
         end

         if (word_hit[c]) begin
            if (phase_q[c] == PH_LOW) begin
               half_d[c]  = intcnct_data_in;
               phase_d[c] = PH_HIGH;
            end else begin
               phase_d[c] = PH_LOW;
            end
         end

         if (push[c]) begin
            mem_d[c][wr_ptr_q[c]] = {intcnct_data_in, half_q[c]};
            wr_ptr_d[c]           = wr_ptr_q[c] + AW'(1);
         end
         if (pop[c]) begin
            rd_ptr_d[c] = rd_ptr_q[c] + AW'(1);
         end
         if (push[c] && !pop[c]) begin
            count_d[c] = count_q[c] + CW'(1);
         end else if (!push[c] && pop[c]) begin
            count_d[c] = count_q[c] - CW'(1);
         end

         credit_d[c] = pop[c];
         if (drop[c]) begin
            overflow_d[c] = 1'b1;
         end
      end
   end

   // State registers. Reset throws away half-built and queued flits
   // without issuing credits; the sender is reset alongside this block and
   // starts again from its full credit count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < 3; c++) begin
            phase_q[c]  <= PH_LOW;
            half_q[c]   <= '0;
            wr_ptr_q[c] <= '0;
            rd_ptr_q[c] <= '0;
            count_q[c]  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
               mem_q[c][i] <= '0;
            end
         end
         credit_q   <= '0;
         overflow_q <= '0;
      end else begin
         for (int c = 0; c < 3; c++) begin
            phase_q[c]  <= phase_d[c];
            half_q[c]   <= half_d[c];
            wr_ptr_q[c] <= wr_ptr_d[c];
            rd_ptr_q[c] <= rd_ptr_d[c];
            count_q[c]  <= count_d[c];
            for (int i = 0; i < FIFO_DEPTH; i++) begin
               mem_q[c][i] <= mem_d[c][i];
            end
         end
         credit_q   <= credit_d;
         overflow_q <= overflow_d;
      end
   end

   assign intcnct_credit_back = credit_q;
   assign overflow_err        = overflow_q;
   assign bout_data_1         = head[0];
   assign bout_data_2         = head[1];
   assign bout_data_3         = head[2];
   assign bout_val_1          = (count_q[0] != '0);
   assign bout_val_2          = (count_q[1] != '0);
   assign bout_val_3          = (count_q[2] != '0);

endmodule

// File: tb/tb_intcnct_flit_deser.sv
// ---------------------------------------------------------------------------
// tb_intcnct_flit_deser
//
// Self-checking bench for intcnct_flit_deser. A table of directed vectors
// covers the basic pairing and cross-channel interleave; hand-written
// sequences cover full-FIFO overflow, push-while-full-with-pop, async reset
// mid-flit and a credit-respecting random traffic run with a scoreboard.
// ---------------------------------------------------------------------------
module tb_intcnct_flit_deser;

   logic        clk;
   logic        rst;
   logic [31:0] dataIn;
   logic [1:0]  channelIn;
   logic [2:0]  creditBack;
   logic [63:0] boutData1;
   logic [63:0] boutData2;
   logic [63:0] boutData3;
   logic        boutVal1;
   logic        boutVal2;
   logic        boutVal3;
   logic [2:0]  rdy;
   logic [2:0]  overflowErr;

   logic [2:0]  val;
   logic [63:0] dout [3];

   int assertCount = 0;
   int failCount   = 0;

   typedef struct {
      logic [1:0]  ch;
      logic [31:0] data;
      logic [2:0]  rdy;
      logic [2:0]  expVal;
      logic [63:0] expD1;
      logic [63:0] expD2;
      logic [63:0] expD3;
      logic [2:0]  expCredit;
      logic [2:0]  expOvf;
   } vec_t;

   vec_t vecs [10];

   intcnct_flit_deser #(.FIFO_DEPTH(8)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .intcnct_data_in     (dataIn),
      .intcnct_channel_in  (channelIn),
      .intcnct_credit_back (creditBack),
      .bout_data_1         (boutData1),
      .bout_data_2         (boutData2),
      .bout_data_3         (boutData3),
      .bout_val_1          (boutVal1),
      .bout_val_2          (boutVal2),
      .bout_val_3          (boutVal3),
      .bout_rdy_1          (rdy[0]),
      .bout_rdy_2          (rdy[1]),
      .bout_rdy_3          (rdy[2]),
      .overflow_err        (overflowErr)
   );

   assign val     = {boutVal3, boutVal2, boutVal1};
   assign dout[0] = boutData1;
   assign dout[1] = boutData2;
   assign dout[2] = boutData3;

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something upstream hangs.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input logic [1:0] ch, input logic [31:0] d,
                                input logic [2:0] r);
      channelIn = ch;
      dataIn    = d;
      rdy       = r;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One word per cycle; returns 1 time unit after the capturing edge.
   task automatic sendWord(input logic [1:0] ch, input logic [31:0] d,
                           input logic [2:0] r);
      applyStimulus(ch, d, r);
      @(posedge clk);
      #1;
   endtask

   task automatic sendFlit(input logic [1:0] ch, input logic [31:0] lo,
                           input logic [31:0] hi, input logic [2:0] r);
      sendWord(ch, lo, r);
      sendWord(ch, hi, r);
   endtask

   task automatic doReset();
      applyStimulus(2'd0, 32'h0, 3'b000);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      logic [63:0] exp3 [9];
      logic [63:0] exp4 [10];
      logic [63:0] sbq [3][$];
      int          credits [3];
      logic        tbPhase [3];
      logic [31:0] tbLo [3];
      int          popCount;
      int          creditCount;
      logic [2:0]  rdyNext;
      logic [1:0]  chNext;
      logic [31:0] wordNext;
      int          pick;

      // Directed vectors: rows 0-3 pair two ch1 words and pop the flit,
      // rows 4-9 interleave halves of ch2 and ch3 and pop both together.
      vecs[0] = '{2'd1, 32'h11111111, 3'b001, 3'b000, 64'h0,
                  64'h0, 64'h0, 3'b000, 3'b000};
      vecs[1] = '{2'd1, 32'h22222222, 3'b001, 3'b001, 64'h2222222211111111,
                  64'h0, 64'h0, 3'b000, 3'b000};
      vecs[2] = '{2'd0, 32'h0, 3'b001, 3'b000, 64'h0,
                  64'h0, 64'h0, 3'b001, 3'b000};
      vecs[3] = '{2'd0, 32'h0, 3'b001, 3'b000, 64'h0,
                  64'h0, 64'h0, 3'b000, 3'b000};
      vecs[4] = '{2'd2, 32'hAAAA0001, 3'b000, 3'b000, 64'h0,
                  64'h0, 64'h0, 3'b000, 3'b000};
      vecs[5] = '{2'd3, 32'hBBBB0002, 3'b000, 3'b000, 64'h0,
                  64'h0, 64'h0, 3'b000, 3'b000};
      vecs[6] = '{2'd2, 32'hCCCC0003, 3'b000, 3'b010, 64'h0,
                  64'hCCCC0003AAAA0001, 64'h0, 3'b000, 3'b000};
      vecs[7] = '{2'd3, 32'hDDDD0004, 3'b000, 3'b110, 64'h0,
                  64'hCCCC0003AAAA0001, 64'hDDDD0004BBBB0002, 3'b000, 3'b000};
      vecs[8] = '{2'd0, 32'h0, 3'b110, 3'b000, 64'h0,
                  64'h0, 64'h0, 3'b110, 3'b000};
      vecs[9] = '{2'd0, 32'h0, 3'b000, 3'b000, 64'h0,
                  64'h0, 64'h0, 3'b000, 3'b000};

      // Reset state
      rst = 1'b1;
      applyStimulus(2'd0, 32'h0, 3'b000);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_val", 64'(val), 64'h0);
      checkOutput("reset_data1", boutData1, 64'h0);
      checkOutput("reset_credit", 64'(creditBack), 64'h0);
      checkOutput("reset_ovf", 64'(overflowErr), 64'h0);
      rst = 1'b0;

      // Table-driven vectors
      $display("[TB] directed vector table");
      for (int i = 0; i < 10; i++) begin
         sendWord(vecs[i].ch, vecs[i].data, vecs[i].rdy);
         checkOutput($sformatf("vec%0d_val", i), 64'(val), 64'(vecs[i].expVal));
         checkOutput($sformatf("vec%0d_d1", i), boutData1, vecs[i].expD1);
         checkOutput($sformatf("vec%0d_d2", i), boutData2, vecs[i].expD2);
         checkOutput($sformatf("vec%0d_d3", i), boutData3, vecs[i].expD3);
         checkOutput($sformatf("vec%0d_credit", i), 64'(creditBack),
                     64'(vecs[i].expCredit));
         checkOutput($sformatf("vec%0d_ovf", i), 64'(overflowErr),
                     64'(vecs[i].expOvf));
      end

      // Fill ch1, overflow with a ninth flit, then drain in order
      $display("[TB] ch1 overflow and drain");
      doReset();
      for (int i = 0; i < 9; i++) begin
         exp3[i] = {32'h20000000 + 32'(i), 32'h10000000 + 32'(i)};
         sendFlit(2'd1, 32'h10000000 + 32'(i), 32'h20000000 + 32'(i), 3'b000);
      end
      checkOutput("ovf_set", 64'(overflowErr), 64'h1);
      checkOutput("ovf_no_credit", 64'(creditBack), 64'h0);
      checkOutput("ovf_val", 64'(val), 64'h1);
      applyStimulus(2'd0, 32'h0, 3'b001);
      for (int k = 0; k < 8; k++) begin
         checkOutput($sformatf("drain%0d_data", k), boutData1, exp3[k]);
         @(posedge clk);
         #1;
         checkOutput($sformatf("drain%0d_credit", k), 64'(creditBack), 64'h1);
      end
      checkOutput("drain_empty", 64'(val), 64'h0);
      applyStimulus(2'd0, 32'h0, 3'b000);
      @(posedge clk);
      #1;
      checkOutput("drain_credit_idle", 64'(creditBack), 64'h0);

      // Push into a full FIFO on the same cycle as a pop
      $display("[TB] push while full with simultaneous pop");
      doReset();
      for (int i = 0; i < 10; i++) begin
         exp4[i] = {32'h40000000 + 32'(i), 32'h30000000 + 32'(i)};
      end
      for (int i = 0; i < 8; i++) begin
         sendFlit(2'd1, exp4[i][31:0], exp4[i][63:32], 3'b000);
      end
      sendWord(2'd1, exp4[8][31:0], 3'b000);
      sendWord(2'd1, exp4[8][63:32], 3'b001);
      checkOutput("swap_ovf", 64'(overflowErr), 64'h0);
      checkOutput("swap_val", 64'(val), 64'h1);
      checkOutput("swap_head", boutData1, exp4[1]);
      checkOutput("swap_credit", 64'(creditBack), 64'h1);
      sendFlit(2'd1, exp4[9][31:0], exp4[9][63:32], 3'b000);
      checkOutput("swap_still_full", 64'(overflowErr), 64'h1);
      applyStimulus(2'd0, 32'h0, 3'b001);
      for (int k = 1; k < 9; k++) begin
         checkOutput($sformatf("swap_drain%0d", k), boutData1, exp4[k]);
         @(posedge clk);
         #1;
      end
      checkOutput("swap_drain_empty", 64'(val), 64'h0);

      // Async reset while a ch2 half is pending and ch3 holds a flit
      $display("[TB] async reset mid-flit");
      sendWord(2'd2, 32'hDEAD0000, 3'b000);
      sendFlit(2'd3, 32'h00000007, 32'h00000008, 3'b000);
      checkOutput("prerst_val3", 64'(val), 64'h4);
      applyStimulus(2'd0, 32'h0, 3'b000);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("rst_async_val", 64'(val), 64'h0);
      checkOutput("rst_async_d3", boutData3, 64'h0);
      checkOutput("rst_async_ovf", 64'(overflowErr), 64'h0);
      checkOutput("rst_async_credit", 64'(creditBack), 64'h0);
      sendWord(2'd2, 32'hBAD0BAD0, 3'b111);
      checkOutput("rst_hold_val", 64'(val), 64'h0);
      checkOutput("rst_hold_d2", boutData2, 64'h0);
      checkOutput("rst_hold_credit", 64'(creditBack), 64'h0);
      rst = 1'b0;
      sendWord(2'd2, 32'h55550001, 3'b000);
      checkOutput("postrst_lo_val", 64'(val), 64'h0);
      sendWord(2'd2, 32'h66660002, 3'b000);
      checkOutput("postrst_val", 64'(val), 64'h2);
      checkOutput("postrst_d2", boutData2, 64'h6666000255550001);
      sendWord(2'd0, 32'h0, 3'b010);
      checkOutput("postrst_credit", 64'(creditBack), 64'h2);

      // Random interleaved traffic with a credit-respecting sender
      $display("[TB] random traffic");
      doReset();
      popCount    = 0;
      creditCount = 0;
      for (int c = 0; c < 3; c++) begin
         credits[c] = 8;
         tbPhase[c] = 1'b0;
         tbLo[c]    = 32'h0;
      end
      for (int cyc = 0; cyc < 2040; cyc++) begin
         for (int c = 0; c < 3; c++) begin
            if (creditBack[c]) begin
               credits[c]++;
               creditCount++;
            end
         end
         rdyNext = (cyc < 2000) ? 3'($urandom_range(0, 7)) : 3'b111;
         for (int c = 0; c < 3; c++) begin
            if (val[c] && rdyNext[c]) begin
               if (sbq[c].size() == 0) begin
                  checkOutput($sformatf("rnd_ch%0d_unexpected", c + 1),
                              64'(val[c]), 64'h0);
               end else begin
                  checkOutput($sformatf("rnd_ch%0d_pop%0d", c + 1, popCount),
                              dout[c], sbq[c][0]);
                  void'(sbq[c].pop_front());
               end
               popCount++;
            end
         end
         chNext   = 2'd0;
         wordNext = 32'h0;
         pick     = (cyc < 2000) ? int'($urandom_range(0, 3)) : 0;
         if (pick != 0) begin
            if (tbPhase[pick - 1] || credits[pick - 1] > 0) begin
               chNext   = 2'(pick);
               wordNext = $urandom;
               if (!tbPhase[pick - 1]) begin
                  credits[pick - 1]--;
                  tbLo[pick - 1]    = wordNext;
                  tbPhase[pick - 1] = 1'b1;
               end else begin
                  sbq[pick - 1].push_back({wordNext, tbLo[pick - 1]});
                  tbPhase[pick - 1] = 1'b0;
               end
            end
         end
         sendWord(chNext, wordNext, rdyNext);
      end
      for (int c = 0; c < 3; c++) begin
         checkOutput($sformatf("rnd_ch%0d_left", c + 1),
                     64'(sbq[c].size()), 64'h0);
      end
      checkOutput("rnd_ovf", 64'(overflowErr), 64'h0);
      checkOutput("rnd_credits", 64'(creditCount), 64'(popCount));
      checkOutput("rnd_final_val", 64'(val), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               assertCount, failCount);
      $finish;
   end

endmodule
